// File: rtl/clkena_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : clkena_gen                                                  |
// | Description : Multi-channel fractional clock-enable generator. Each       |
// |               channel emits one-cycle enable pulses at refclk*NUM/DEN     |
// |               using a Bresenham phase accumulator. The locked output      |
// |               rises once every channel is valid and the configuration     |
// |               has been stable for LOCK_CYCLES cycles.                     |
// | Options     : CLKENA_TOGGLE_EN adds the outtgl port, which has one        |
// |               toggle flop per channel that flips on every enable pulse.   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module clkena_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 64
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [CHANNELS*ACC_W-1:0] num,
    input  logic [CHANNELS*ACC_W-1:0] den,
    output logic [CHANNELS-1:0]       ce,
    output logic                      locked,
    output logic [CHANNELS-1:0]       cfg_err
`ifdef CLKENA_TOGGLE_EN
    ,
    output logic [CHANNELS-1:0]       outtgl
`endif
);

    localparam int                 c_CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LOCK  = c_CNT_W'(LOCK_CYCLES);

    logic [CHANNELS-1:0] w_change;
    logic [CHANNELS-1:0] w_valid;
    logic [CHANNELS-1:0] w_ce_vec;
    logic [CHANNELS-1:0] w_err_vec;
`ifdef CLKENA_TOGGLE_EN
    logic [CHANNELS-1:0] w_tgl_vec;
`endif

    logic [c_CNT_W-1:0]  r_lock_cnt;
    logic                r_locked;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [ACC_W-1:0] w_num;
            logic [ACC_W-1:0] w_den;
            logic [ACC_W:0]   w_sum;
            logic [ACC_W:0]   w_sub;
            logic             w_hit;
            logic             w_ce_next;
            logic [ACC_W-1:0] r_num_sh;
            logic [ACC_W-1:0] r_den_sh;
            logic [ACC_W-1:0] r_acc;
            logic             r_ce;
            logic             r_cfg_err;

            assign w_num       = num[i*ACC_W +: ACC_W];
            assign w_den       = den[i*ACC_W +: ACC_W];
            assign w_change[i] = (w_num != r_num_sh) || (w_den != r_den_sh);
            assign w_valid[i]  = (w_den != '0) && (w_num <= w_den);

            // One extra bit keeps acc+num exact; acc<den and num<=den bound the sum below 2*den.
            assign w_sum     = {1'b0, r_acc} + {1'b0, w_num};
            assign w_sub     = w_sum - {1'b0, w_den};
            assign w_hit     = (w_sum >= {1'b0, w_den});
            assign w_ce_next = !w_change[i] && w_valid[i] && !hold && w_hit;

            // Shadow config, error flag, accumulator and enable pulse for this channel.
            always_ff @(posedge refclk) begin
                if (rst) begin
                    r_num_sh  <= '0;
                    r_den_sh  <= '0;
                    r_acc     <= '0;
                    r_ce      <= 1'b0;
                    r_cfg_err <= 1'b0;
                end else begin
                    r_num_sh  <= w_num;
                    r_den_sh  <= w_den;
                    r_cfg_err <= !w_valid[i];
                    r_ce      <= w_ce_next;
                    if (w_change[i] || !w_valid[i]) begin
                        r_acc <= '0;
                    end else if (!hold) begin
                        r_acc <= w_hit ? w_sub[ACC_W-1:0] : w_sum[ACC_W-1:0];
                    end
                end
            end

            assign w_ce_vec[i]  = r_ce;
            assign w_err_vec[i] = r_cfg_err;

`ifdef CLKENA_TOGGLE_EN
            logic r_tgl;

            // Square-wave output flips whenever an enable pulse is registered.
            always_ff @(posedge refclk) begin
                if (rst) begin
                    r_tgl <= 1'b0;
                end else if (w_ce_next) begin
                    r_tgl <= ~r_tgl;
                end
            end

            assign w_tgl_vec[i] = r_tgl;
`endif
        end : g_ch
    endgenerate

    // Saturating stability counter, cleared by any configuration change, frozen by hold.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_cnt <= '0;
        end else if (|w_change) begin
            r_lock_cnt <= '0;
        end else if (!hold && (r_lock_cnt != c_LOCK)) begin
            r_lock_cnt <= r_lock_cnt + c_CNT_W'(1);
        end
    end

    // Lock status: needs a saturated counter and no invalid channel; hold keeps the last value.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_locked <= 1'b0;
        end else if (|w_change) begin
            r_locked <= 1'b0;
        end else if (!hold) begin
            r_locked <= (r_lock_cnt == c_LOCK) && !(|(~w_valid));
        end
    end

    assign ce      = w_ce_vec;
    assign cfg_err = w_err_vec;
    assign locked  = r_locked;
`ifdef CLKENA_TOGGLE_EN
    assign outtgl  = w_tgl_vec;
`endif

endmodule : clkena_gen
`default_nettype wire

// File: doc/clkena_gen.md
# clkena_gen

Multi-channel fractional clock-enable generator; the single-clock, parametrised successor to our fixed two-output PLL wrappers. Derives CHANNELS independent one-cycle enable pulses from `refclk`, each at a runtime-programmable rate of `refclk` × NUM/DEN. Core logic runs on one clock domain and uses the enables instead of extra PLL outputs. A `locked` status mirrors PLL semantics: high only when every channel is validly configured and its configuration has been stable for LOCK_CYCLES.

## Interface
- CHANNELS, 2, number of enable channels (1..8)
- ACC_W, 16, width of NUM/DEN per channel and of each phase accumulator
- LOCK_CYCLES, 64, stable cycles required before `locked` rises (≥1)
- refclk  in  1  sole clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- hold  in  1  freeze all accumulators, force all `ce` low
- num  in  CHANNELS*ACC_W  per-channel numerator, channel i at [i*ACC_W +: ACC_W]
- den  in  CHANNELS*ACC_W  per-channel denominator, same packing
- ce  out  CHANNELS  one-cycle enable pulse per channel
- locked  out  1  all channels valid and configuration stable
- cfg_err  out  CHANNELS  channel i has invalid configuration

## Operation
- Channel valid iff den≠0 and num≤den; invalid channel: `ce[i]`=0, accumulator held at 0, `cfg_err[i]`=1.
- Per valid channel each cycle with hold=0: sum = acc + num (ACC_W+1 bits, no overflow); if sum ≥ den then acc←sum−den, ce←1, else acc←sum, ce←0.
- num=den: `ce` high every cycle; num=0: `ce` never high.
- Long-run pulse rate exactly num/den of `refclk`; pulse spacing differs by at most 1 cycle (Bresenham).
- Config registers: num/den sampled into shadow registers every cycle; mismatch between input and shadow for channel i = config change: acc[i]←0, ce[i]←0 that cycle, lock counter cleared.
- Lock counter: saturating, clog2(LOCK_CYCLES+1) bits; increments each cycle with no config change; `locked`=1 when counter = LOCK_CYCLES and no `cfg_err` bit set.
- hold=1: accumulators and counter frozen, `ce` all 0, `locked` keeps its value; config changes during hold still clear acc and lock counter.
- Simultaneous config change and hold: config change wins (acc cleared).

## Timing
- Reset values: ce=0, locked=0, cfg_err=0, all acc=0, shadows=0, lock counter=0.
- First cycle after rst release: every channel with nonzero num/den sees a config change (shadow=0), so acc restarts from 0 one cycle later.
- ce registered: sum computed in cycle n appears on `ce` after edge n+1.
- num=1, den=2: first `ce` pulse on the 3rd edge after rst release, then every 2 cycles.
- `locked` rises LOCK_CYCLES+1 edges after last config change; falls on the edge after a config change or any cfg_err.
- `cfg_err` registered, 1-cycle latency from num/den.
- rst asserted mid-operation: all outputs return to reset values on that edge, regardless of hold.

## Configuration
- CLKENA_TOGGLE_EN defined: adds output port `outtgl` (CHANNELS bits), each bit toggles on the edge where its `ce` bit is registered high; reset 0, held during hold and for invalid channels; gives a near-50% square wave at half the enable rate for pin/debug use.
- Not defined: `outtgl` port and its flops absent; remaining behaviour identical.

## Test plan
- rst 4 cycles, CHANNELS=2, ch0 num=12 den=25, ch1 num=24 den=25 -> over 2500 cycles ch0 exactly 1200 pulses, ch1 2400; pulse gaps ch0 ∈{2,3}.
- ch0 num=1 den=2 after reset release -> first ce[0] on edge 3, then alternating; locked rises on edge LOCK_CYCLES+2 (66 with defaults).
- Locked steady, change ch1 den 25→50 -> locked low next edge, ce[1] low that cycle, locked back after 65 edges, ch1 rate halves.
- ch0 den=0, then num=5 den=4 -> cfg_err[0]=1 one edge later, ce[0] stays 0, locked 0; restore num=1 den=1 -> ce[0] high every cycle, locked after 65 edges.
- hold=1 for 10 cycles mid-stream -> ce all 0, locked unchanged, pulse sequence resumes exactly where frozen (same acc values).
- rst pulse mid-stream with CLKENA_TOGGLE_EN -> ce, locked, cfg_err, outtgl all 0 on next edge; outtgl[0] period = 2×ce period afterwards.
